ex_muldiv_unit: RTL

Iterative multi-cycle integer multiply/divide unit that runs beside the single-cycle EX ALU. It takes already-forwarded operands from the execute stage and computes MUL, MULH, MULHU, DIV, DIVU, REM or REMU. While it works, busy stalls IF/ID/EX. When finished, it returns the result and destination register to EX/MEM with a one-cycle done pulse.

---
 rtl/ex_muldiv_unit_pkg.sv | 33 +++
 rtl/ex_muldiv_unit_md_div_step.sv | 29 ++
 rtl/ex_muldiv_unit.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared types for the iterative multiply/divide unit beside the EX ALU.
package ex_muldiv_unit_pkg;

    localparam int MD_XLEN    = 32;
    localparam int MD_RADDR_W = 5;

    typedef enum logic [2:0] {
        MD_MUL   = 3'd0,
        MD_MULH  = 3'd1,
        MD_MULHU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_REM   = 3'd5,
        MD_REMU  = 3'd6
    } md_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } md_state_e;

    // Request bundle on the ID/EX -> unit path.
    typedef struct packed {
        md_op_e                  op;
        logic [MD_XLEN-1:0]      a;
        logic [MD_XLEN-1:0]      b;
        logic [MD_RADDR_W-1:0]   rd_addr;
    } md_params_t;

endpackage

// File: rtl/ex_muldiv_unit_md_div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference if it did not borrow.
module md_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0] partial;
    logic [XLEN:0] diff;

    // Trial subtract; diff MSB set means the divisor did not fit.
    always_comb begin
        partial = {rem_in, quo_in[XLEN-1]};
        diff    = partial - {1'b0, divisor};
        if (!diff[XLEN]) begin
            rem_out = diff[XLEN-1:0];
            quo_out = {quo_in[XLEN-2:0], 1'b1};
        end else begin
            rem_out = partial[XLEN-1:0];
            quo_out = {quo_in[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative MUL/MULH/MULHU/DIV/DIVU/REM/REMU unit. Operands are turned into
// magnitudes at accept, iterated unsigned, and sign-corrected in FIX.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 2,
    parameter int RADDR_W  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [XLEN-1:0]    op_a,
    input  logic [XLEN-1:0]    op_b,
    input  logic [RADDR_W-1:0] rd_addr_in,
    input  logic               flush,
    output logic               busy,
    output logic               done,
    output logic [XLEN-1:0]    result,
    output logic [RADDR_W-1:0] rd_addr_out
);

    localparam int N_MUL = XLEN / MUL_BITS;
    localparam int CNT_W = $clog2(XLEN + 1);
    localparam int XP    = XLEN + MUL_BITS;

    md_state_e          state;
    md_op_e             op_r;
    logic [RADDR_W-1:0] rd_r;
    logic               neg_r;
    logic [CNT_W-1:0]   cnt;
    logic [XLEN-1:0]    mcand;
    logic [2*XLEN-1:0]  acc;

    md_op_e             op_in;
    logic               is_signed_in;
    logic               is_div_in;
    logic               is_rem_in;
    logic               a_neg;
    logic               b_neg;
    logic [XLEN-1:0]    abs_a;
    logic [XLEN-1:0]    abs_b;
    logic               div_zero;
    logic               div_ovf;
    logic [XLEN-1:0]    fast_result;
    logic               accept;

    logic [XP-1:0]      mul_partial;
    logic [XP-1:0]      mul_upper;
    logic [2*XLEN-1:0]  mul_next;
    logic [XLEN-1:0]    div_rem;
    logic [XLEN-1:0]    div_quo;
    logic [2*XLEN-1:0]  prod_fix;
    logic [XLEN-1:0]    fix_result;

    assign accept = start && !flush && (state == ST_IDLE || state == ST_DONE);
    assign busy   = accept || state == ST_MUL || state == ST_DIV || state == ST_FIX;
    assign done   = (state == ST_DONE);

    // Decode the incoming request: magnitudes, sign flags and fast-path outcomes.
    always_comb begin
        op_in        = md_op_e'(op);
        is_signed_in = (op_in == MD_MULH) || (op_in == MD_DIV) || (op_in == MD_REM);
        is_div_in    = (op_in == MD_DIV) || (op_in == MD_DIVU) ||
                       (op_in == MD_REM) || (op_in == MD_REMU);
        is_rem_in    = (op_in == MD_REM) || (op_in == MD_REMU);
        a_neg        = is_signed_in && op_a[XLEN-1];
        b_neg        = is_signed_in && op_b[XLEN-1];
        abs_a        = a_neg ? -op_a : op_a;
        abs_b        = b_neg ? -op_b : op_b;
        div_zero     = (op_b == '0);
        div_ovf      = ((op_in == MD_DIV) || (op_in == MD_REM)) &&
                       (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        // Overflow quotient is MIN, which is op_a itself.
        if (is_rem_in)
            fast_result = div_zero ? op_a : '0;
        else
            fast_result = div_zero ? '1 : op_a;
    end

    // Multiply retires MUL_BITS multiplier bits from the low half of acc per cycle.
    always_comb begin
        mul_partial = XP'(mcand) * XP'(acc[MUL_BITS-1:0]);
        mul_upper   = XP'(acc[2*XLEN-1:XLEN]) + mul_partial;
        mul_next    = {mul_upper, acc[XLEN-1:MUL_BITS]};
    end

    md_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_in  (acc[2*XLEN-1:XLEN]),
        .quo_in  (acc[XLEN-1:0]),
        .divisor (mcand),
        .rem_out (div_rem),
        .quo_out (div_quo)
    );

    // Sign correction and word selection for the finished iteration.
    always_comb begin
        prod_fix = neg_r ? -acc : acc;
        case (op_r)
            MD_MUL:   fix_result = acc[XLEN-1:0];
            MD_MULH:  fix_result = prod_fix[2*XLEN-1:XLEN];
            MD_MULHU: fix_result = acc[2*XLEN-1:XLEN];
            MD_DIV:   fix_result = neg_r ? -acc[XLEN-1:0] : acc[XLEN-1:0];
            MD_DIVU:  fix_result = acc[XLEN-1:0];
            MD_REM:   fix_result = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
            default:  fix_result = acc[2*XLEN-1:XLEN];
        endcase
    end

    // Sequencer: accept, iterate, fix up, pulse done; flush aborts without commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            op_r        <= MD_MUL;
            rd_r        <= '0;
            neg_r       <= 1'b0;
            cnt         <= '0;
            mcand       <= '0;
            acc         <= '0;
            result      <= '0;
            rd_addr_out <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        op_r  <= op_in;
                        rd_r  <= rd_addr_in;
                        neg_r <= is_rem_in ? a_neg : (a_neg ^ b_neg);
                        if (is_div_in && (div_zero || div_ovf)) begin
                            result      <= fast_result;
                            rd_addr_out <= rd_addr_in;
                            state       <= ST_DONE;
                        end else if (is_div_in) begin
                            mcand <= abs_b;
                            acc   <= {{XLEN{1'b0}}, abs_a};
                            cnt   <= CNT_W'(XLEN);
                            state <= ST_DIV;
                        end else begin
                            mcand <= abs_a;
                            acc   <= {{XLEN{1'b0}}, abs_b};
                            cnt   <= CNT_W'(N_MUL);
                            state <= ST_MUL;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    acc <= mul_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1))
                        state <= ST_FIX;
                end
                ST_DIV: begin
                    acc <= {div_rem, div_quo};
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1))
                        state <= ST_FIX;
                end
                ST_FIX: begin
                    result      <= fix_result;
                    rd_addr_out <= rd_r;
                    state       <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
